// File: rtl/pipe_addsub_n_pkg.sv
// rtl/pipe_addsub_n_pkg.sv - operation encodings and parameter guard shared by pipe_addsub_n
`ifndef PIPE_ADDSUB_N_PKG_SV
`define PIPE_ADDSUB_N_PKG_SV

`define PIPE_ADDSUB_N_CHECK(w, n) \
  if ((w) < 1 || (n) < 1 || ((w) % (n)) != 0) begin : g_param_check \
    $error("pipe_addsub_n: WIDTH must be a nonzero multiple of STAGES"); \
  end

package pipe_addsub_n_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

`endif

// File: rtl/fa_1.sv
// rtl/fa_1.sv - 1-bit full adder made of two half-adder cells and a carry OR
module fa_1 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a_i ^ b_i;
  assign ha0_c = a_i & b_i;
  assign s_o   = ha0_s ^ c_i;
  assign ha1_c = ha0_s & c_i;
  assign c_o   = ha0_c | ha1_c;
endmodule

// File: rtl/pipe_addsub_n.sv
// rtl/pipe_addsub_n.sv - pipelined WIDTH-bit adder/subtractor, one CW-bit carry chunk per stage
module pipe_addsub_n
  import pipe_addsub_n_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;

  `PIPE_ADDSUB_N_CHECK(WIDTH, STAGES)

  logic             cin0;
  logic [WIDTH-1:0] b_eff;

  assign cin0  = (sub == OP_SUB);
  assign b_eff = b ^ {WIDTH{cin0}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = WIDTH - k * CW;
    localparam int LO = k * CW;

    logic             vin;
    logic             cin;
    logic [HI-1:0]    a_in;
    logic [HI-1:0]    b_in;
    logic [CW:0]      c;
    logic [CW-1:0]    sum;
    logic [LO+CW-1:0] res_d;
    logic [LO+CW-1:0] res_q;
    logic             vld_q;
    logic             cy_q;

    // Unconsumed operand chunks shift down so this stage always adds bits [CW-1:0].
    if (k == 0) begin : g_head
      assign vin   = in_valid;
      assign cin   = cin0;
      assign a_in  = a;
      assign b_in  = b_eff;
      assign res_d = sum;
    end else begin : g_body
      assign vin   = g_stage[k-1].vld_q;
      assign cin   = g_stage[k-1].cy_q;
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign res_d = {sum, g_stage[k-1].res_q};
    end

    assign c[0] = cin;
    for (genvar i = 0; i < CW; i++) begin : g_bit
      fa_1 u_fa (
        .a_i (a_in[i]),
        .b_i (b_in[i]),
        .c_i (c[i]),
        .s_o (sum[i]),
        .c_o (c[i+1])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vin;
        if (vin) begin
          cy_q  <= c[CW];
          res_q <= res_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [HI-CW-1:0] a_q;
      logic [HI-CW-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (vin) begin
          a_q <= a_in[HI-1:CW];
          b_q <= b_in[HI-1:CW];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // c[CW-1] is the carry into the result MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (vin) begin
          ovf_q <= c[CW] ^ c[CW-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign s         = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].cy_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipe_addsub_n.sv
// tb/tb_pipe_addsub_n.sv - bench for pipe_addsub_n at STAGES=2, 1 and 8
module tb_pipe_addsub_n;
  import pipe_addsub_n_pkg::*;

  localparam int ND = 3;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sb;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 sub;
  logic [7:0]           a;
  logic [7:0]           b;
  logic [ND-1:0]        ov;
  logic [ND-1:0]        cv;
  logic [ND-1:0]        fv;
  logic [ND-1:0][7:0]   sv;

  res_t hr [0:2047];
  logic hv [0:2047];
  res_t hold [ND];
  int   n;
  int   mark;
  int   pass_cnt;
  int   chk_cnt;
  vec_t tbl [7];

  always #5 clk = ~clk;

  pipe_addsub_n #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .out_valid(ov[0]), .s(sv[0]), .cout(cv[0]), .ovf(fv[0])
  );
  pipe_addsub_n #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .out_valid(ov[1]), .s(sv[1]), .cout(cv[1]), .ovf(fv[1])
  );
  pipe_addsub_n #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .out_valid(ov[2]), .s(sv[2]), .cout(cv[2]), .ovf(fv[2])
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic res_t ref_op(input logic [7:0] x, input logic [7:0] y, input logic sb);
    res_t r;
    int   u;
    int   sr;
    if (sb == OP_SUB) begin
      u   = int'(x) - int'(y);
      sr  = int'($signed(x)) - int'($signed(y));
      r.c = (x >= y);
    end else begin
      u   = int'(x) + int'(y);
      sr  = int'($signed(x)) + int'($signed(y));
      r.c = (u > 255);
    end
    r.s = u[7:0];
    r.o = (sr > 127) || (sr < -128);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input logic v, input logic [7:0] x, input logic [7:0] y, input logic sb);
    logic ev;
    int   src;
    in_valid = v;
    a        = x;
    b        = y;
    sub      = sb;
    @(posedge clk);
    #1;
    n++;
    hv[n] = v;
    hr[n] = ref_op(x, y, sb);
    for (int d = 0; d < ND; d++) begin
      src = n - lat_of(d) + 1;
      ev  = 1'b0;
      if (src >= mark && hv[src]) begin
        ev      = 1'b1;
        hold[d] = hr[src];
      end
      chk($sformatf("dut%0d cyc%0d out_valid", d, n), 32'(ov[d]), 32'(ev));
      chk($sformatf("dut%0d cyc%0d s", d, n), 32'(sv[d]), 32'(hold[d].s));
      chk($sformatf("dut%0d cyc%0d cout", d, n), 32'(cv[d]), 32'(hold[d].c));
      chk($sformatf("dut%0d cyc%0d ovf", d, n), 32'(fv[d]), 32'(hold[d].o));
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    tbl[0] = '{8'h0F, 8'h01, OP_ADD, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h07, OP_SUB, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h5A, 8'h00, OP_SUB, 8'h5A, 1'b1, 1'b0};

    pass_cnt = 0;
    chk_cnt  = 0;
    n        = 0;
    mark     = 1 << 30;
    for (int d = 0; d < ND; d++) hold[d] = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;

    tick(1'b1, 8'h12, 8'h34, 1'b0);
    idle(2);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d reset out_valid", d), 32'(ov[d]), 32'd0);
      chk($sformatf("dut%0d reset s", d), 32'(sv[d]), 32'd0);
      chk($sformatf("dut%0d reset cout", d), 32'(cv[d]), 32'd0);
      chk($sformatf("dut%0d reset ovf", d), 32'(fv[d]), 32'd0);
    end
    rst  = 1'b0;
    mark = n + 1;

    foreach (tbl[r]) begin
      tick(1'b1, tbl[r].a, tbl[r].b, tbl[r].sb);
      idle(9);
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("vec%0d dut%0d s", r, d), 32'(sv[d]), 32'(tbl[r].es));
        chk($sformatf("vec%0d dut%0d cout", r, d), 32'(cv[d]), 32'(tbl[r].ec));
        chk($sformatf("vec%0d dut%0d ovf", r, d), 32'(fv[d]), 32'(tbl[r].eo));
      end
    end

    tick(1'b1, 8'h01, 8'h02, OP_ADD);
    tick(1'b1, 8'h03, 8'h04, OP_ADD);
    chk("b2b first valid", 32'(ov[0]), 32'd1);
    chk("b2b first s", 32'(sv[0]), 32'h03);
    tick(1'b0, 8'hAA, 8'hBB, OP_ADD);
    chk("b2b second valid", 32'(ov[0]), 32'd1);
    chk("b2b second s", 32'(sv[0]), 32'h07);
    tick(1'b1, 8'hF0, 8'h10, OP_ADD);
    chk("b2b bubble valid", 32'(ov[0]), 32'd0);
    chk("b2b bubble hold s", 32'(sv[0]), 32'h07);
    idle(1);
    chk("b2b fourth valid", 32'(ov[0]), 32'd1);
    chk("b2b fourth s", 32'(sv[0]), 32'h00);
    chk("b2b fourth cout", 32'(cv[0]), 32'd1);
    idle(8);

    tick(1'b1, 8'h11, 8'h22, OP_ADD);
    tick(1'b1, 8'h33, 8'h44, OP_SUB);
    #1;
    rst  = 1'b1;
    mark = 1 << 30;
    for (int d = 0; d < ND; d++) hold[d] = '0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d async rst out_valid", d), 32'(ov[d]), 32'd0);
      chk($sformatf("dut%0d async rst s", d), 32'(sv[d]), 32'd0);
      chk($sformatf("dut%0d async rst cout", d), 32'(cv[d]), 32'd0);
      chk($sformatf("dut%0d async rst ovf", d), 32'(fv[d]), 32'd0);
    end
    tick(1'b1, 8'h55, 8'h66, OP_ADD);
    tick(1'b1, 8'h77, 8'h88, OP_ADD);
    rst  = 1'b0;
    mark = n + 1;
    idle(10);
    tick(1'b1, 8'hAA, 8'h55, OP_ADD);
    idle(9);

    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    idle(9);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/pipe_addsub_n.md
Name: pipe_addsub_n

Overview:
Parametrised, pipelined N-bit adder/subtractor, the next generation of the team's 1-bit half-adder cell.
- Splits the operands into STAGES equal chunks and resolves one chunk's carry chain per clock.
- Runs at full throughput with a valid-only stream: one operation accepted per cycle, no backpressure.
- Used as the arithmetic datapath element in counters, ALU and accumulator blocks on the FPGA board designs.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- STAGES, 2, number of pipeline stages and therefore the latency in cycles; WIDTH % STAGES must equal 0 and STAGES ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b and sub are valid this cycle.
- sub  input  1  0 = a+b, 1 = a−b.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- out_valid  output  1  s, cout and ovf hold a new result.
- s  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Chunk width is CW = WIDTH/STAGES. Stage k (k=0..STAGES−1) adds bits [k*CW +: CW].
- Subtract is implemented as a + ~b + 1. The operand B XOR sub is formed at input, and sub is the carry-in to stage 0.
- Stage k registers:
  - its CW result bits;
  - its carry out, which feeds stage k+1's carry-in on the next cycle;
  - the lower result chunks already computed, delayed alongside;
  - the upper operand chunks not yet added, skewed forward.
- Latency is exactly STAGES cycles: an input with in_valid=1 at edge n produces out_valid=1 at edge n+STAGES.
- STAGES=1 gives a single registered ripple adder with latency 1.
- Valid is a STAGES-deep shift register and is cleared on reset.
- Each stage's data registers load only when that stage's incoming valid is 1; otherwise they hold.
- s, cout and ovf therefore hold the last result while out_valid=0.
- Throughput is 1 op/cycle. Back-to-back inputs emerge on consecutive cycles in order. Bubbles are preserved exactly.
- The output stage computes ovf from the final stage's carry-in to the MSB and its carry out.
- Reset values: out_valid=0, s=0, cout=0, ovf=0, all internal stage and valid registers 0.
- Reset asserted mid-operation discards all in-flight operations. No result from before reset ever appears after reset.
- After rst deasserts, the first accepted input appears STAGES cycles later.
- Boundary behaviour:
  - 0xFF+0x01 wraps to 0x00 with cout=1.
  - 0x00−0x01 gives 0xFF with cout=0 (borrow).
  - Any-value−0 gives cout=1.
  - An input while out_valid is high is normal pipelining, not a conflict.
- Outputs are driven only from registers: no combinational path from inputs to outputs.

Decomposition:
- Shared package/include:
  - OP_ADD=1'b0 and OP_SUB=1'b1 encodings for sub;
  - a parameter-check macro that fails elaboration if WIDTH % STAGES ≠ 0.
- One natural sub-module: fa_1, a 1-bit full adder built from two half-adder cells plus an OR for carry.
- Stage chunk adders are generated as CW chained fa_1 instances.
- The pipeline skew registers live in the top module via generate loops.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- a=0x0F, b=0x01, sub=0, in_valid pulse at cycle 0 → out_valid=1 at cycle 2 with s=0x10, cout=0, ovf=0. Intermediate carry crosses the chunk boundary.
- a=0xFF, b=0x01, sub=0 → s=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → s=0x80, cout=0, ovf=1.
- sub=1: a=0x05, b=0x07 → s=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01 → s=0x7F, cout=1, ovf=1.
- Four back-to-back inputs: (1,2), (3,4), bubble, (0xF0,0x10) → out_valid pattern 1,1,0,1 starting at cycle 2.
  - Results are 0x03, 0x07, 0x00 with cout=1.
  - s holds 0x07 during the bubble.
- Assert rst asynchronously one cycle after two inputs were issued → outputs zero immediately. No stale result appears after deassertion.
- Repeat the first three scenarios with STAGES=1 (latency 1) and STAGES=8 (latency 8) → identical results at the new latency.
